// File: rtl/alu_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_pkg
// Description : Shared constants for the MIPS execute stage: datapath width,
//               the 16 alu_ctr operation codes and the write-back selects.
//               Optional feature macro: MULDIV_EN (see alu_core/alu_exec_unit).
// Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_pkg;

    localparam int ALU_WIDTH = 32;

    // alu_ctr operation codes
    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_XOR   = 4'd3;
    localparam logic [3:0] ALU_NOR   = 4'd4;
    localparam logic [3:0] ALU_SLTU  = 4'd5;
    localparam logic [3:0] ALU_SUB   = 4'd6;
    localparam logic [3:0] ALU_SLT   = 4'd7;
    localparam logic [3:0] ALU_SLL   = 4'd8;
    localparam logic [3:0] ALU_SRL   = 4'd9;
    localparam logic [3:0] ALU_SRA   = 4'd10;
    localparam logic [3:0] ALU_LUI   = 4'd11;
    localparam logic [3:0] ALU_MULT  = 4'd12;
    localparam logic [3:0] ALU_MULTU = 4'd13;
    localparam logic [3:0] ALU_DIV   = 4'd14;
    localparam logic [3:0] ALU_DIVU  = 4'd15;

    // mem_to_reg write-back selects (code 3 yields zero)
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // Codes 12..15 are exactly the ones with both top bits set.
    function automatic logic is_muldiv(input logic [3:0] ctr);
        return ctr[3] & ctr[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit_if
// Description : Execute-stage bus. The master (decode/control side) drives
//               operands, selects and write-back sources; the slave (the
//               execute unit) returns ALU result, flags, HI/LO and wb_data.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_exec_unit_if;
    import alu_exec_pkg::*;

    logic [ALU_WIDTH-1:0] reg_a;
    logic [ALU_WIDTH-1:0] reg_b;
    logic [4:0]           shamt;
    logic [ALU_WIDTH-1:0] imm;
    logic                 alu_src_a;
    logic                 alu_src_b;
    logic [3:0]           alu_ctr;
    logic [ALU_WIDTH-1:0] mem_data;
    logic [ALU_WIDTH-1:0] pc_plus4;
    logic [1:0]           mem_to_reg;
    logic [ALU_WIDTH-1:0] alu_res;
    logic                 zero;
    logic                 ovf;
    logic [ALU_WIDTH-1:0] hi;
    logic [ALU_WIDTH-1:0] lo;
    logic [ALU_WIDTH-1:0] wb_data;

    modport master (
        output reg_a, reg_b, shamt, imm, alu_src_a, alu_src_b, alu_ctr,
               mem_data, pc_plus4, mem_to_reg,
        input  alu_res, zero, ovf, hi, lo, wb_data
    );

    modport slave (
        input  reg_a, reg_b, shamt, imm, alu_src_a, alu_src_b, alu_ctr,
               mem_data, pc_plus4, mem_to_reg,
        output alu_res, zero, ovf, hi, lo, wb_data
    );

endinterface
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Combinational ALU: op decode, result, zero, raw signed
//               overflow and the next-HI/LO values for mul/div.
//               Macro MULDIV_EN: when undefined no mul/div hardware is built
//               and hilo_we_o / hi_next_o / lo_next_o are tied to 0.
// Ports       : op_a_i, op_b_i   - selected operands
//               alu_ctr_i        - operation code
//               result_o, zero_o, ovf_o
//               hilo_we_o        - HI/LO load enable (mul/div, no div-by-0)
//               hi_next_o, lo_next_o
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  wire logic [WIDTH-1:0] op_a_i,
    input  wire logic [WIDTH-1:0] op_b_i,
    input  wire logic [3:0]       alu_ctr_i,
    output logic      [WIDTH-1:0] result_o,
    output logic                  zero_o,
    output logic                  ovf_o,
    output logic                  hilo_we_o,
    output logic      [WIDTH-1:0] hi_next_o,
    output logic      [WIDTH-1:0] lo_next_o
);

    logic [4:0]       w_shamt;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;

    assign w_shamt = op_a_i[4:0];
    assign w_sum   = op_a_i + op_b_i;
    assign w_diff  = op_a_i - op_b_i;

    always_comb begin
        result_o = '0;
        case (alu_ctr_i)
            ALU_AND:  result_o = op_a_i & op_b_i;
            ALU_OR:   result_o = op_a_i | op_b_i;
            ALU_ADD:  result_o = w_sum;
            ALU_XOR:  result_o = op_a_i ^ op_b_i;
            ALU_NOR:  result_o = ~(op_a_i | op_b_i);
            ALU_SLTU: result_o = {{(WIDTH-1){1'b0}}, (op_a_i < op_b_i)};
            ALU_SUB:  result_o = w_diff;
            ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
            ALU_SLL:  result_o = op_b_i << w_shamt;
            ALU_SRL:  result_o = op_b_i >> w_shamt;
            ALU_SRA:  result_o = $signed(op_b_i) >>> w_shamt;
            ALU_LUI:  result_o = {op_b_i[15:0], 16'h0000};
            default:  result_o = '0;   // mul/div codes produce no ALU result
        endcase
    end

    assign zero_o = (result_o == '0);

    // Raw two's-complement overflow; masking for unsigned forms is done upstream.
    always_comb begin
        ovf_o = 1'b0;
        case (alu_ctr_i)
            ALU_ADD: ovf_o = (op_a_i[WIDTH-1] == op_b_i[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != op_a_i[WIDTH-1]);
            ALU_SUB: ovf_o = (op_a_i[WIDTH-1] != op_b_i[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != op_a_i[WIDTH-1]);
            default: ovf_o = 1'b0;
        endcase
    end

`ifdef MULDIV_EN
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic               w_div_zero;
    logic               w_div_signed;
    logic [WIDTH-1:0]   w_divisor;
    logic [WIDTH-1:0]   w_dvd;
    logic [WIDTH-1:0]   w_dvs;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quo_s;
    logic [WIDTH-1:0]   w_rem_s;

    // Sign-extending to 2*WIDTH makes the low half of a plain product signed.
    assign w_prod_s = {{WIDTH{op_a_i[WIDTH-1]}}, op_a_i} *
                      {{WIDTH{op_b_i[WIDTH-1]}}, op_b_i};
    assign w_prod_u = {{WIDTH{1'b0}}, op_a_i} * {{WIDTH{1'b0}}, op_b_i};

    // A single unsigned divider serves both forms: signed division works on
    // magnitudes and fixes the signs afterwards. The divisor is forced to 1
    // on divide-by-zero only to keep the datapath well defined; the write
    // enable is suppressed in that case anyway.
    assign w_div_zero   = (op_b_i == '0);
    assign w_div_signed = (alu_ctr_i == ALU_DIV);
    assign w_divisor    = w_div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : op_b_i;
    assign w_dvd        = (w_div_signed && op_a_i[WIDTH-1])    ? -op_a_i    : op_a_i;
    assign w_dvs        = (w_div_signed && w_divisor[WIDTH-1]) ? -w_divisor : w_divisor;
    assign w_quo        = w_dvd / w_dvs;
    assign w_rem        = w_dvd % w_dvs;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    assign w_quo_s      = (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]) ? -w_quo : w_quo;
    assign w_rem_s      = op_a_i[WIDTH-1] ? -w_rem : w_rem;

    always_comb begin
        hi_next_o = '0;
        lo_next_o = '0;
        case (alu_ctr_i)
            ALU_MULT:  {hi_next_o, lo_next_o} = w_prod_s;
            ALU_MULTU: {hi_next_o, lo_next_o} = w_prod_u;
            ALU_DIV: begin
                hi_next_o = w_rem_s;
                lo_next_o = w_quo_s;
            end
            ALU_DIVU: begin
                hi_next_o = w_rem;
                lo_next_o = w_quo;
            end
            default: begin
                hi_next_o = '0;
                lo_next_o = '0;
            end
        endcase
    end

    assign hilo_we_o = is_muldiv(alu_ctr_i) &&
                       !(((alu_ctr_i == ALU_DIV) || (alu_ctr_i == ALU_DIVU)) && w_div_zero);
`else
    assign hilo_we_o = 1'b0;
    assign hi_next_o = '0;
    assign lo_next_o = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute stage of the single-cycle MIPS datapath: operand
//               muxes, ALU core, HI/LO registers and write-back select.
//               Everything is combinational except HI/LO.
//               Macro MULDIV_EN: defined builds HI/LO and mul/div; undefined
//               ties hi/lo to 0 and codes 12..15 only give alu_res = 0.
// Ports       : clk   - CPU clock (HI/LO update on rising edge)
//               reset - synchronous active-high, clears HI/LO
//               bus   - alu_exec_unit_if.slave (operands, selects, results)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH   // only 32 is supported
) (
    input  wire logic       clk,
    input  wire logic       reset,
    alu_exec_unit_if.slave  bus
);

    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_alu_res;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;
    logic             w_hilo_we;

    assign w_op_a = bus.alu_src_a ? {{(WIDTH-5){1'b0}}, bus.shamt} : bus.reg_a;
    assign w_op_b = bus.alu_src_b ? bus.imm : bus.reg_b;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .op_a_i    (w_op_a),
        .op_b_i    (w_op_b),
        .alu_ctr_i (bus.alu_ctr),
        .result_o  (w_alu_res),
        .zero_o    (bus.zero),
        .ovf_o     (bus.ovf),
        .hilo_we_o (w_hilo_we),
        .hi_next_o (w_hi_next),
        .lo_next_o (w_lo_next)
    );

    assign bus.alu_res = w_alu_res;

`ifdef MULDIV_EN
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (w_hilo_we) begin
            hi_d = w_hi_next;
            lo_d = w_lo_next;
        end
    end

    // Reset wins over a mul/div in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
`else
    // No HI/LO storage in this build; clock, reset and the core's
    // next-HI/LO outputs have no consumer.
    logic unused_muldiv;
    assign unused_muldiv = ^{clk, reset, w_hilo_we, w_hi_next, w_lo_next};

    assign bus.hi = '0;
    assign bus.lo = '0;
`endif

    always_comb begin
        bus.wb_data = '0;
        case (bus.mem_to_reg)
            WB_ALU:  bus.wb_data = w_alu_res;
            WB_MEM:  bus.wb_data = bus.mem_data;
            WB_PC4:  bus.wb_data = bus.pc_plus4;
            default: bus.wb_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Self-checking bench for alu_exec_unit. A behavioural model
//               (signed/unsigned integer arithmetic on 64-bit values) is
//               compared against the DUT on every falling edge; directed
//               literal cases pin the model. Works with or without MULDIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;
    import alu_exec_pkg::*;

`ifdef MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    bit          cmp_en = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    alu_exec_unit_if bus ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sel_a(input logic src, input logic [4:0] sh, input logic [31:0] ra);
        return src ? {27'b0, sh} : ra;
    endfunction

    // Returns {ovf, result}
    function automatic logic [32:0] model_alu(input logic [3:0] ctr, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, s;
        logic [31:0] r;
        logic        v;
        sa = $signed(a);
        sb = $signed(b);
        r  = '0;
        v  = 1'b0;
        case (ctr)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2: begin
                s = sa + sb;
                r = s[31:0];
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd3:  r = a ^ b;
            4'd4:  r = ~(a | b);
            4'd5:  r = (a < b) ? 32'd1 : 32'd0;
            4'd6: begin
                s = sa - sb;
                r = s[31:0];
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  r = b << a[4:0];
            4'd9:  r = b >> a[4:0];
            4'd10: begin
                s = sb >>> a[4:0];
                r = s[31:0];
            end
            4'd11: r = {b[15:0], 16'h0};
            default: r = '0;
        endcase
        return {v, r};
    endfunction

    // HI/LO reference state
    always @(posedge clk) begin
        if (reset) begin
            m_hi = '0;
            m_lo = '0;
        end
`ifdef MULDIV_EN
        else begin
            logic [31:0]      a, b;
            longint           sa, sb, p, q, rm;
            longint unsigned  ua, ub, pu;
            a  = sel_a(bus.alu_src_a, bus.shamt, bus.reg_a);
            b  = bus.alu_src_b ? bus.imm : bus.reg_b;
            sa = $signed(a);
            sb = $signed(b);
            ua = {32'b0, a};
            ub = {32'b0, b};
            case (bus.alu_ctr)
                4'd12: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
                4'd13: begin pu = ua * ub; m_hi = pu[63:32]; m_lo = pu[31:0]; end
                4'd14: if (b != 0) begin
                    q = sa / sb; rm = sa % sb; m_lo = q[31:0]; m_hi = rm[31:0];
                end
                4'd15: if (b != 0) begin
                    pu = ua / ub; m_lo = pu[31:0]; pu = ua % ub; m_hi = pu[31:0];
                end
                default: ;
            endcase
        end
`endif
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [32:0] e;
            logic [31:0] ewb;
            e = model_alu(bus.alu_ctr, sel_a(bus.alu_src_a, bus.shamt, bus.reg_a),
                          bus.alu_src_b ? bus.imm : bus.reg_b);
            case (bus.mem_to_reg)
                2'd0:    ewb = e[31:0];
                2'd1:    ewb = bus.mem_data;
                2'd2:    ewb = bus.pc_plus4;
                default: ewb = '0;
            endcase
            chk("alu_res", bus.alu_res, e[31:0]);
            chk("zero", {31'b0, bus.zero}, {31'b0, (e[31:0] == 32'd0)});
            chk("ovf", {31'b0, bus.ovf}, {31'b0, e[32]});
            chk("wb_data", bus.wb_data, ewb);
            chk("hi", bus.hi, m_hi);
            chk("lo", bus.lo, m_lo);
        end
    end

    task automatic apply(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b,
                         input logic src_a, input logic src_b, input logic [4:0] sh,
                         input logic [31:0] im);
        @(posedge clk);
        #1;
        bus.alu_ctr   = ctr;
        bus.reg_a     = a;
        bus.reg_b     = b;
        bus.alu_src_a = src_a;
        bus.alu_src_b = src_b;
        bus.shamt     = sh;
        bus.imm       = im;
        #1;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 16));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] wb_exp [4];
        wb_exp = '{32'h10, 32'h20, 32'h30, 32'h0};

        reset          = 1'b1;
        bus.alu_ctr    = ALU_AND;
        bus.reg_a      = '0;
        bus.reg_b      = '0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 1'b0;
        bus.shamt      = '0;
        bus.imm        = '0;
        bus.mem_to_reg = WB_ALU;
        bus.mem_data   = 32'h20;
        bus.pc_plus4   = 32'h30;
        cmp_en         = 1'b1;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset_hi", bus.hi, 32'h0);
        chk("reset_lo", bus.lo, 32'h0);

        apply(ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 0, 0);
        chk("and", bus.alu_res, 32'h00F000F0);
        apply(ALU_SLT, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 0);
        chk("slt", bus.alu_res, 32'h1);
        apply(ALU_SLTU, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 0);
        chk("sltu", bus.alu_res, 32'h0);
        chk("sltu_zero", {31'b0, bus.zero}, 32'h1);
        apply(ALU_ADD, 32'h7FFFFFFF, 32'h1, 0, 0, 0, 0);
        chk("add_ovf_res", bus.alu_res, 32'h80000000);
        chk("add_ovf", {31'b0, bus.ovf}, 32'h1);
        apply(ALU_SUB, 32'd5, 32'd5, 0, 0, 0, 0);
        chk("sub_res", bus.alu_res, 32'h0);
        chk("sub_zero", {31'b0, bus.zero}, 32'h1);
        chk("sub_noovf", {31'b0, bus.ovf}, 32'h0);
        apply(ALU_SUB, 32'h80000000, 32'h1, 0, 0, 0, 0);
        chk("sub_ovf_res", bus.alu_res, 32'h7FFFFFFF);
        chk("sub_ovf", {31'b0, bus.ovf}, 32'h1);
        apply(ALU_SRA, 32'h0, 32'h80000000, 1, 0, 5'd4, 0);
        chk("sra", bus.alu_res, 32'hF8000000);
        apply(ALU_SRL, 32'h0, 32'h80000000, 1, 0, 5'd4, 0);
        chk("srl", bus.alu_res, 32'h08000000);
        apply(ALU_LUI, 32'h0, 32'h0, 0, 1, 0, 32'h00001234);
        chk("lui", bus.alu_res, 32'h12340000);

        apply(ALU_MULT, 32'hFFFFFFFE, 32'd3, 0, 0, 0, 0);
        chk("mult_res", bus.alu_res, 32'h0);
        chk("mult_zero", {31'b0, bus.zero}, 32'h1);
        apply(ALU_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, 0, 0);
        chk("mult_hi", bus.hi, MD ? 32'hFFFFFFFF : 32'h0);
        chk("mult_lo", bus.lo, MD ? 32'hFFFFFFFA : 32'h0);
        apply(ALU_DIVU, 32'd5, 32'd0, 0, 0, 0, 0);
        chk("div_hi", bus.hi, MD ? 32'hFFFFFFFF : 32'h0);
        chk("div_lo", bus.lo, MD ? 32'hFFFFFFFD : 32'h0);
        apply(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0);
        chk("divz_hi", bus.hi, MD ? 32'hFFFFFFFF : 32'h0);
        chk("divz_lo", bus.lo, MD ? 32'hFFFFFFFD : 32'h0);
        apply(ALU_MULT, 32'd3, 32'd5, 0, 0, 0, 0);
        chk("divmin_hi", bus.hi, 32'h0);
        chk("divmin_lo", bus.lo, MD ? 32'h80000000 : 32'h0);

        // Reset together with an active MULT (HI/LO currently non-zero)
        reset = 1'b1;
        apply(ALU_ADD, 32'd2, 32'd2, 0, 0, 0, 0);
        reset = 1'b0;
        chk("rst_mult_hi", bus.hi, 32'h0);
        chk("rst_mult_lo", bus.lo, 32'h0);
        apply(ALU_OR, 32'd1, 32'd2, 0, 0, 0, 0);
        chk("hold_lo", bus.lo, 32'h0);
        apply(ALU_MULTU, 32'd3, 32'd5, 0, 0, 0, 0);
        apply(ALU_AND, 32'd0, 32'd0, 0, 0, 0, 0);
        chk("reload_lo", bus.lo, MD ? 32'd15 : 32'h0);

        apply(ALU_ADD, 32'h8, 32'h8, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            bus.mem_to_reg = 2'(i);
            #1;
            chk("wb_mux", bus.wb_data, wb_exp[i]);
        end

        // Randomized phase, checked by the negedge compare process
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            reset          = ($urandom_range(0, 63) == 0);
            bus.alu_ctr    = 4'($urandom_range(0, 15));
            bus.reg_a      = rnd_val();
            bus.reg_b      = ($urandom_range(0, 7) == 0) ? 32'h0 : rnd_val();
            bus.imm        = rnd_val();
            bus.shamt      = 5'($urandom);
            bus.alu_src_a  = ($urandom_range(0, 3) == 0);
            bus.alu_src_b  = ($urandom_range(0, 3) == 0);
            bus.mem_to_reg = 2'($urandom);
            bus.mem_data   = $urandom;
            bus.pc_plus4   = $urandom;
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1;
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute stage of the single-cycle MIPS datapath.
- Contains:
  - the ALU operand-select muxes (A: rs value or shamt; B: rt value or extended immediate);
  - the ALU core;
  - the HI/LO registers;
  - the 3-way register write-back select (ALU result, memory data, PC+4).
- Everything is combinational except HI/LO, which update on the CPU clock.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported.

Ports:
- clk  input  1  CPU clock; HI/LO update on rising edge.
- reset  input  1  synchronous, active-high; clears HI/LO.
- reg_a  input  32  rs read data.
- reg_b  input  32  rt read data; also the store data path.
- shamt  input  5  instruction[10:6].
- imm  input  32  extended immediate.
- alu_src_a  input  1  0: reg_a; 1: zero-extended shamt.
- alu_src_b  input  1  0: reg_b; 1: imm.
- alu_ctr  input  4  operation code (see Behaviour).
- mem_data  input  32  data-memory read result.
- pc_plus4  input  32  link value.
- mem_to_reg  input  2  write-back select.
- alu_res  output  32  ALU result; also the data-memory address.
- zero  output  1  1 when alu_res == 0.
- ovf  output  1  raw signed overflow of ADD/SUB.
- hi  output  32  HI register.
- lo  output  32  LO register.
- wb_data  output  32  register-file write data.

Behaviour:
- Operand selection:
  - opA = alu_src_a ? {27'b0, shamt} : reg_a.
  - opB = alu_src_b ? imm : reg_b.
- alu_ctr encoding:
  - 0 AND: A&B.
  - 1 OR: A|B.
  - 2 ADD: A+B.
  - 3 XOR: A^B.
  - 4 NOR: ~(A|B).
  - 5 SLTU: unsigned A<B, result 1/0.
  - 6 SUB: A-B.
  - 7 SLT: signed A<B.
  - 8 SLL: B<<A[4:0].
  - 9 SRL: B>>A[4:0], logical.
  - 10 SRA: B>>>A[4:0], arithmetic.
  - 11 LUI: {B[15:0], 16'h0}.
  - 12 MULT, 13 MULTU, 14 DIV, 15 DIVU.
- Arithmetic width: ADD/SUB wrap modulo 2^32.
- ovf (raw; the instruction-level mask lives outside this block):
  - ADD: set when both operands have the same sign and the result sign differs.
  - SUB: set when the operand signs differ and the result sign differs from A.
  - All other codes: 0.
- Codes 12–15: alu_res = 0, so zero = 1.
- Next-HI/LO computation (combinational):
  - MULT/MULTU: 64-bit signed/unsigned product; HI gets bits [63:32], LO gets bits [31:0].
  - DIV/DIVU: LO = quotient, truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divisor 0: HI/LO are not written.
- HI/LO registers:
  - Rising clk with reset = 1: both cleared to 0. Reset has priority over a concurrent mul/div.
  - Otherwise, on rising clk with alu_ctr in 12–15 (and not a divide-by-zero): load the next-HI/LO values.
  - Otherwise: hold.
- Write-back: mem_to_reg 0 → alu_res; 1 → mem_data; 2 → pc_plus4; 3 → 0.
- Reset affects only HI/LO. All other outputs are purely combinational and valid within the same cycle, with zero latency.

Optional Feature:
- Macro MULDIV_EN.
- Defined: codes 12–15 and the HI/LO registers behave as above.
- Undefined:
  - No multiplier/divider hardware and no HI/LO registers; hi and lo are tied to 0.
  - Codes 12–15 give alu_res = 0, ovf = 0, zero = 1.

Decomposition:
- Package alu_exec_pkg holds:
  - localparams for all 16 alu_ctr codes;
  - the mem_to_reg selects (WB_ALU = 0, WB_MEM = 1, WB_PC4 = 2);
  - the WIDTH default.
- One sub-module: alu_core, the combinational op decode plus result, zero, ovf and the next-HI/LO computation.
- Operand muxes, HI/LO registers and the write-back mux stay in alu_exec_unit.

Test Plan:
- Logic/compare:
  - AND, 0xF0F0F0F0 & 0x0FF00FF0 → 0x00F000F0.
  - SLT, 0xFFFFFFFF vs 1 → 1.
  - SLTU, same operands → 0, with zero = 1.
- Add/sub overflow:
  - ADD 0x7FFFFFFF + 1 → 0x80000000, ovf = 1.
  - SUB 5 − 5 → 0, zero = 1, ovf = 0.
  - SUB 0x80000000 − 1 → ovf = 1.
- Shifts and LUI:
  - alu_src_a = 1, shamt = 4; SRA of 0x80000000 → 0xF8000000; SRL → 0x08000000.
  - LUI with imm = 0x00001234 → 0x12340000.
- Mul/div:
  - MULT 0xFFFFFFFE × 3 → after clk, hi = 0xFFFFFFFF, lo = 0xFFFFFFFA.
  - DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - DIVU by 0 → HI/LO unchanged.
- Reset:
  - Load HI/LO, then assert reset for one edge together with MULT active → hi = lo = 0.
  - Deassert reset → HI/LO hold until the next mul/div.
- Write-back mux: mem_to_reg 0/1/2/3 with alu_res = 0x10, mem_data = 0x20, pc_plus4 = 0x30 → wb_data 0x10/0x20/0x30/0x0.
